// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants and helpers for the shared-multiplier arbiter.
//   width_default  : default operand width
//   n_req_default  : default requester count
//   id_width()     : requester ID width for a given count (at least 1 bit)
package mult_share_arbiter_pkg;

    localparam int unsigned WidthDefault = 17;
    localparam int unsigned NReqDefault  = 4;

    // clog2 with a floor of 1 so a single requester still has a 1-bit ID.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational signed radix-2 Booth multiplier.
//   a, b    : two's complement operands, WIDTH bits
//   product : full-width signed product, 2*WIDTH bits
module multiplier #(
    parameter int unsigned WIDTH = 17
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] a_ext;
    logic [WIDTH:0]     b_ext;
    logic [2*WIDTH-1:0] acc;

    always_comb begin
        a_ext = {{WIDTH{a[WIDTH-1]}}, a};
        // Implicit zero below the LSB starts the Booth recoding.
        b_ext = {b, 1'b0};
        acc   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case (b_ext[i+1 -: 2])
                2'b01:   acc = acc + (a_ext << i);
                2'b10:   acc = acc - (a_ext << i);
                default: acc = acc;
            endcase
        end
        product = acc;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//   req      : request vector
//   advance  : a grant was consumed this cycle; move the pointer to it
//   grant    : one-hot grant, search starts just after the last grant
//   grant_id : binary index of grant
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    localparam int NInt = int'(N);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            found;
    int              idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int off = 0; off < NInt; off++) begin
            idx = (int'(ptr_q) + 1 + off) % NInt;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
        ptr_d = advance ? grant_id : ptr_q;
    end

    // Pointer holds the last granted index; N-1 makes requester 0 win first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= ID_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one signed multiplier between N_REQ requesters.
// Round-robin pick -> operand register -> multiplier -> result register.
//   req_valid/req_ready : per-requester handshake, req_ready is one-hot or zero
//   req_a/req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/ready    : result handshake
//   resp_id             : requester owning resp_result
//   resp_result         : full-width signed product
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault,
    parameter int unsigned N_REQ = NReqDefault,
    parameter int unsigned ID_W  = id_width(NReqDefault)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [2*WIDTH-1:0]     resp_result
);

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_id;
    logic               s2_load;
    logic               can_accept;
    logic               accept;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [ID_W-1:0]    op_id_q, op_id_d;
    logic               op_valid_q, op_valid_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [2*WIDTH-1:0] resp_result_q, resp_result_d;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req_valid),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    multiplier #(
        .WIDTH (WIDTH)
    ) u_mult (
        .a       (op_a_q),
        .b       (op_b_q),
        .product (product)
    );

    always_comb begin
        s2_load    = op_valid_q & (~resp_valid_q | resp_ready);
        // Stage 1 may refill in the same cycle it hands its operands on.
        can_accept = ~op_valid_q | s2_load;
        // Gated by reset so nothing looks accepted while state is being cleared.
        req_ready  = reset ? '0 : (grant & {N_REQ{can_accept}});
        accept     = |req_ready;

        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_id_d    = op_id_q;
        op_valid_d = op_valid_q;
        if (accept) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (grant[i]) begin
                    op_a_d = req_a[i*WIDTH +: WIDTH];
                    op_b_d = req_b[i*WIDTH +: WIDTH];
                end
            end
            op_id_d    = grant_id;
            op_valid_d = 1'b1;
        end else if (s2_load) begin
            op_valid_d = 1'b0;
        end

        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        if (s2_load) begin
            resp_valid_d  = 1'b1;
            resp_id_d     = op_id_q;
            resp_result_d = product;
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_id_q       <= '0;
            op_valid_q    <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
        end else begin
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_id_q       <= op_id_d;
            op_valid_q    <= op_valid_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: vector table, corner sequences,
// and a queue scoreboard fed by every accepted request.
module tb_mult_share_arbiter;

    localparam int W  = 17;
    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_a;
    logic [N*W-1:0]    req_b;
    logic [N-1:0]      req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [IW-1:0]     resp_id;
    logic [2*W-1:0]    resp_result;

    mult_share_arbiter #(
        .WIDTH (W),
        .N_REQ (N),
        .ID_W  (IW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard entry: owner ID and full-width product.
    typedef struct {
        int     id;
        longint res;
    } sb_t;
    sb_t sb[$];

    logic signed [2*W-1:0] xa, xb, xp;
    logic                  hold_prev;
    logic [IW-1:0]         id_prev;
    logic [2*W-1:0]        res_prev;
    int                    acc_cnt;

    initial acc_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    xa = $signed(req_a[i*W +: W]);
                    xb = $signed(req_b[i*W +: W]);
                    xp = xa * xb;
                    sb.push_back('{id: i, res: longint'(xp)});
                    acc_cnt++;
                end
            end
            check("ready_onehot", longint'($countones(req_ready) <= 1), 1);
            check("ready_subset", longint'(req_ready & ~req_valid), 0);
            if (hold_prev) begin
                check("bp_valid_hold", longint'(resp_valid), 1);
                check("bp_id_hold", longint'(resp_id), longint'(id_prev));
                check("bp_res_hold", longint'(resp_result), longint'(res_prev));
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_resp", 1, 0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("sb_id", longint'(resp_id), longint'(e.id));
                    check("sb_result", longint'($signed(resp_result)), e.res);
                end
            end
            hold_prev = resp_valid && !resp_ready;
            id_prev   = resp_id;
            res_prev  = resp_result;
        end
    end

    typedef struct {
        int     id;
        longint a;
        longint b;
        longint r;
    } vec_t;
    vec_t vecs[7];

    logic [N-1:0] rdy;
    int           grants[8];
    int           ng;
    logic [N-1:0] v;

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, longint'(sb.size()), 0);
    endtask

    initial begin
        vecs[0] = '{id: 2, a: 3,      b: -5,     r: -15};
        vecs[1] = '{id: 0, a: -65536, b: -65536, r: 64'sd4294967296};
        vecs[2] = '{id: 1, a: -65536, b: 65535,  r: -64'sd4294901760};
        vecs[3] = '{id: 3, a: 0,      b: -1,     r: 0};
        vecs[4] = '{id: 0, a: 65535,  b: 65535,  r: 64'sd4294836225};
        vecs[5] = '{id: 1, a: -1,     b: -1,     r: 1};
        vecs[6] = '{id: 3, a: 12345,  b: -678,   r: -8369910};

        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        hold_prev  = 1'b0;
        #12;
        check("rst_ready", longint'(req_ready), 0);
        check("rst_valid", longint'(resp_valid), 0);
        check("rst_id", longint'(resp_id), 0);
        check("rst_result", longint'(resp_result), 0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Table: lone request, ready in the same cycle, result two edges later.
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            req_valid                   = '0;
            req_valid[vecs[k].id]       = 1'b1;
            req_a[vecs[k].id*W +: W]    = W'(vecs[k].a);
            req_b[vecs[k].id*W +: W]    = W'(vecs[k].b);
            @(negedge clk);
            check("vec_ready", longint'(req_ready), longint'(1 << vecs[k].id));
            @(posedge clk);
            #1 req_valid = '0;
            @(negedge clk);
            check("vec_lat_early", longint'(resp_valid), 0);
            @(negedge clk);
            check("vec_valid", longint'(resp_valid), 1);
            check("vec_id", longint'(resp_id), longint'(vecs[k].id));
            check("vec_result", longint'($signed(resp_result)), vecs[k].r);
        end
        drain("vec_drain");

        // Fill both stages behind a stalled output, then reset between edges.
        @(posedge clk);
        #1;
        resp_ready   = 1'b0;
        req_valid    = 4'b0010;
        req_a[W +: W] = W'(7);
        req_b[W +: W] = W'(9);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_full", longint'(resp_valid), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", longint'(req_ready), 0);
        check("mid_rst_valid", longint'(resp_valid), 0);
        check("mid_rst_id", longint'(resp_id), 0);
        check("mid_rst_result", longint'(resp_result), 0);
        sb.delete();
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
        end
        @(posedge clk);
        #2 reset = 1'b0;

        // Fairness: everyone requesting, grants must rotate from requester 0.
        ng = 0;
        for (int c = 0; c < 20 && ng < 8; c++) begin
            @(negedge clk);
            rdy = req_ready;
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    grants[ng] = i;
                    ng++;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = W'($urandom);
                end
            end
        end
        check("fair_count", longint'(ng), 8);
        for (int k = 0; k < 8; k++) begin
            check("fair_order", longint'(grants[k]), longint'(k % N));
        end

        // Backpressure: stall output, both stages hold one product each.
        resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready_low", longint'(req_ready), 0);
            check("bp_buffered", longint'(sb.size()), 2);
            @(posedge clk);
            #1;
        end
        resp_ready = 1'b1;
        req_valid  = '0;
        drain("bp_drain");

        // Random traffic with held requests and random output stalls.
        acc_cnt = 0;
        v       = '0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (v[i] && rdy[i]) begin
                    v[i] = 1'b0;
                end
                if (!v[i] && ($urandom_range(0, 1) == 1)) begin
                    v[i]            = 1'b1;
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = W'($urandom);
                end
            end
            req_valid  = v;
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        drain("rand_drain");
        check("rand_activity", longint'(acc_cnt > 200), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
